uart_tx_stimulus: RTL and testbench
===================================

// Module: uart_tx_stimulus
//
// PURPOSE
//   Byte-oriented UART transmitter with an input FIFO.
//   Drives the SoC UART_RX line in simulation, and serves as the SoC TX path in RTL.
//   Serialises 8N1-style frames (STOP_BITS configurable) at BAUD_RATE from CLK_FREQ_MHZ.
//   Counterpart to uart_baud_monitor: its frames must decode byte-exact there.
//
// PARAMETERS
//   CLK_FREQ_MHZ  27      system clock frequency, MHz
//   BAUD_RATE     115200  line rate, bits/s
//   FIFO_DEPTH    16      input FIFO entries; power of two, >= 2
//   STOP_BITS     1       stop bits per frame: 1 or 2
//
// PORTS
//   clk         in   1                 system clock
//   reset       in   1                 synchronous, active-low reset
//   in_valid    in   1                 byte offered on in_byte
//   in_byte     in   8                 byte to transmit
//   in_ready    out  1                 FIFO can accept a byte
//   uart_tx     out  1                 serial line, idle high
//   busy        out  1                 frame in progress or FIFO non-empty
//   fifo_count  out  $clog2(DEPTH)+1   bytes queued, excluding the frame on the wire
//
// BEHAVIOUR
//   Reset and registers
//   - Reset (reset==0 at posedge clk): uart_tx=1, in_ready=1, busy=0, fifo_count=0.
//   - Reset also returns the FSM to IDLE and flushes the FIFO.
//   - Reset mid-frame aborts the frame; uart_tx is high after that edge.
//   - uart_tx is a register output (no combinational path from in_*).
//
//   Bit timing and framing
//   - BIT_CYCLES = (CLK_FREQ_MHZ*1_000_000)/BAUD_RATE, truncated.
//     The default is 234 clk per bit.
//   - Baud counter is $clog2(BIT_CYCLES) bits; it reloads at every bit boundary, no drift carry.
//   - Frame: 1 start bit (0), 8 data bits LSB first, STOP_BITS stop bits (1).
//     Each bit holds exactly BIT_CYCLES clocks.
//
//   Handshake and FIFO
//   - Push on posedge when in_valid && in_ready.
//   - in_ready = (fifo_count < FIFO_DEPTH).
//   - in_valid while full is ignored; the byte is dropped and no state changes.
//   - Simultaneous push and pop: fifo_count unchanged, both operations take effect.
//   - Pointers wrap modulo FIFO_DEPTH.
//   - fifo_count is exact and ranges 0..FIFO_DEPTH.
//
//   FSM
//   - States: IDLE, START, DATA, STOP.
//   - IDLE: uart_tx=1. If FIFO non-empty: pop into shift reg, uart_tx<=0, baud cnt<=0, go START.
//   - START: after BIT_CYCLES: uart_tx<=shift[0], bit idx<=0, go DATA.
//   - DATA: every BIT_CYCLES, shift right and drive the next bit.
//     After bit 7 has held BIT_CYCLES: uart_tx<=1, go STOP.
//   - STOP: hold for STOP_BITS*BIT_CYCLES. Then:
//     if FIFO non-empty, pop, uart_tx<=0, go START (no idle gap);
//     else go IDLE.
//
//   Latency and status
//   - Latency: byte pushed at edge N into empty FIFO while IDLE.
//     uart_tx falls after edge N+1.
//   - Frame: 10*BIT_CYCLES clocks (11* with STOP_BITS=2).
//   - busy = (state!=IDLE) || (fifo_count!=0).
//
// TESTING
//   1. Reset low 3 clk, release, hold in_valid=0 for 1000 clk
//      -> uart_tx=1, busy=0, fifo_count=0 throughout.
//   2. Push 8'h41 when IDLE -> uart_tx low 1 clk after the push.
//      Sampled at bit centres: 0,1,0,0,0,0,0,1,0,1.
//      Line returns high; monitor prints "A"; frame = 2340 clk.
//   3. Push "Hello\n" back-to-back
//      -> 6 contiguous frames, no gap (stop-to-start = 234 clk high).
//      Monitor prints "Hello\n"; busy drops 14040 clk after first start edge.
//   4. Push 17 bytes 8'h00..8'h10 in 17 consecutive clk with in_valid=1
//      -> in_ready deasserts once 16 bytes are queued.
//      The dropped byte is 8'h10; 8'h00..8'h0F transmit in order.
//   5. Assert reset 1000 clk into a frame of 8'hA5 with 3 bytes queued
//      -> uart_tx=1 next clk, fifo_count=0, nothing else sent.
//   6. STOP_BITS=2, push 8'hFF, 8'h00 back-to-back
//      -> start edges 2574 clk apart; monitor reads FF then 00.

Source files
------------

// File: rtl/uart_tx_stimulus.sv
// uart_tx_stimulus: FIFO-buffered UART transmitter emitting start, 8 data bits LSB first
// and STOP_BITS stop bits at BAUD_RATE derived from CLK_FREQ_MHZ.
module uart_tx_stimulus #(
    parameter int CLK_FREQ_MHZ = 27,
    parameter int BAUD_RATE    = 115200,
    parameter int FIFO_DEPTH   = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic [7:0]                  in_byte,
    output logic                        in_ready,
    output logic                        uart_tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int BIT_CYCLES = (CLK_FREQ_MHZ * 1_000_000) / BAUD_RATE;
    localparam int CW = BIT_CYCLES > 1 ? $clog2(BIT_CYCLES) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(BIT_CYCLES - 1);
    localparam logic [CNTW-1:0] FULL = CNTW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      idx_q;
    logic [7:0]      shift_q;
    logic            tx_q;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_q, rd_q;
    logic [CNTW-1:0] count_q, count_d;
    logic            bit_done, frame_end, push, pop;

    assign bit_done  = cnt_q == LAST_CNT;
    assign frame_end = state_q == STOP && bit_done && idx_q == 3'(STOP_BITS - 1);
    assign pop       = count_q != '0 && (state_q == IDLE || frame_end);
    assign push      = in_valid && in_ready;

    always_comb count_d = count_q + CNTW'(push) - CNTW'(pop);

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= in_byte;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= push ? wr_q + 1'b1 : wr_q;
            rd_q    <= pop ? rd_q + 1'b1 : rd_q;
            count_q <= count_d;
        end
    end

    // idx_q counts data bits in DATA and stop bits in STOP
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q <= bit_done ? '0 : cnt_q + 1'b1;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (pop) begin
                        shift_q <= mem_q[rd_q];
                        tx_q    <= 1'b0;
                        state_q <= START;
                    end
                end
                START: if (bit_done) begin
                    tx_q    <= shift_q[0];
                    shift_q <= shift_q >> 1;
                    idx_q   <= '0;
                    state_q <= DATA;
                end
                DATA: if (bit_done) begin
                    if (idx_q == 3'd7) begin
                        tx_q    <= 1'b1;
                        idx_q   <= '0;
                        state_q <= STOP;
                    end else begin
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        idx_q   <= idx_q + 1'b1;
                    end
                end
                STOP: if (bit_done) begin
                    if (frame_end) begin
                        if (pop) begin
                            shift_q <= mem_q[rd_q];
                            tx_q    <= 1'b0;
                            state_q <= START;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign uart_tx    = tx_q;
    assign in_ready   = count_q < FULL;
    assign busy       = state_q != IDLE || count_q != '0;
    assign fifo_count = count_q;
endmodule

// File: tb/tb_uart_tx_stimulus.sv
// tb_uart_tx_stimulus: directed bench with a serial decoder per DUT feeding a byte scoreboard.
module tb_uart_tx_stimulus;
    localparam int BIT = 234;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid_a = 1'b0, in_valid_b = 1'b0;
    logic [7:0] in_byte_a = '0, in_byte_b = '0;
    logic       in_ready_a, in_ready_b, tx_a, tx_b, busy_a, busy_b;
    logic [4:0] fifo_count_a, fifo_count_b;

    int vec = 0, bad = 0, cyc = 0;
    logic [7:0] exp_a[$], exp_b[$];
    int starts_a[$], starts_b[$];

    uart_tx_stimulus #(.STOP_BITS(1)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_byte(in_byte_a),
        .in_ready(in_ready_a), .uart_tx(tx_a), .busy(busy_a), .fifo_count(fifo_count_a)
    );

    uart_tx_stimulus #(.STOP_BITS(2)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_byte(in_byte_b),
        .in_ready(in_ready_b), .uart_tx(tx_b), .busy(busy_b), .fifo_count(fifo_count_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        vec++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // Samples one frame at bit centres; ab flags a reset seen mid-frame
    task automatic rx_frame(input bit sel, output logic [9:0] fr, output bit ab);
        ab = 1'b0;
        repeat (BIT / 2) begin @(negedge clk); if (!reset) ab = 1'b1; end
        fr[0] = sel ? tx_b : tx_a;
        for (int i = 1; i < 10; i++) begin
            repeat (BIT) begin @(negedge clk); if (!reset) ab = 1'b1; end
            fr[i] = sel ? tx_b : tx_a;
        end
    endtask

    initial begin : mon_a
        logic [9:0] fr;
        bit ab;
        int t;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (reset && tx_a === 1'b0) begin
                t = cyc;
                rx_frame(1'b0, fr, ab);
                if (!ab) begin
                    starts_a.push_back(t);
                    chk("frame_expected_a", 32'(exp_a.size() > 0), 1);
                    if (exp_a.size() > 0) begin
                        e = exp_a.pop_front();
                        chk("frame_a", 32'(fr), 32'({1'b1, e, 1'b0}));
                    end
                end
            end
        end
    end

    initial begin : mon_b
        logic [9:0] fr;
        bit ab;
        int t;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (reset && tx_b === 1'b0) begin
                t = cyc;
                rx_frame(1'b1, fr, ab);
                if (!ab) begin
                    starts_b.push_back(t);
                    chk("frame_expected_b", 32'(exp_b.size() > 0), 1);
                    if (exp_b.size() > 0) begin
                        e = exp_b.pop_front();
                        chk("frame_b", 32'(fr), 32'({1'b1, e, 1'b0}));
                    end
                end
            end
        end
    end

    task automatic push_a(input logic [7:0] b);
        in_valid_a = 1'b1;
        in_byte_a  = b;
        exp_a.push_back(b);
        @(posedge clk); #1;
        in_valid_a = 1'b0;
    endtask

    task automatic push_b(input logic [7:0] b);
        in_valid_b = 1'b1;
        in_byte_b  = b;
        exp_b.push_back(b);
        @(posedge clk); #1;
        in_valid_b = 1'b0;
    endtask

    task automatic wait_idle(input bit sel, input int limit, output int t_done);
        int n = 0;
        do begin @(posedge clk); #1; n++; end while ((sel ? busy_b : busy_a) && n < limit);
        chk(sel ? "idle_timeout_b" : "idle_timeout_a", 32'(n < limit), 1);
        t_done = cyc;
    endtask

    initial begin
        int t0, t_done, errs;
        string hello;
        hello = "Hello\n";
        // 1: reset then long idle
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", 32'(tx_a), 1);
        chk("rst_ready", 32'(in_ready_a), 1);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_count", 32'(fifo_count_a), 0);
        chk("rst_tx_b", 32'(tx_b), 1);
        chk("rst_count_b", 32'(fifo_count_b), 0);
        reset = 1'b1;
        errs = 0;
        repeat (1000) begin
            @(posedge clk); #1;
            if (tx_a !== 1'b1 || busy_a !== 1'b0 || fifo_count_a !== 5'd0) errs++;
        end
        chk("idle_quiet", 32'(errs), 0);
        // 2: single byte latency and frame length
        push_a(8'h41);
        chk("lat_tx_push_edge", 32'(tx_a), 1);
        chk("lat_count", 32'(fifo_count_a), 1);
        @(posedge clk); #1;
        chk("lat_tx_fall", 32'(tx_a), 0);
        chk("lat_count_popped", 32'(fifo_count_a), 0);
        t0 = cyc;
        wait_idle(1'b0, 3000, t_done);
        chk("frame_len", 32'(t_done - t0), 2340);
        chk("line_high", 32'(tx_a), 1);
        chk("a_drained", 32'(exp_a.size()), 0);
        // 3: back-to-back string
        starts_a.delete();
        for (int i = 0; i < hello.len(); i++) push_a(hello[i]);
        wait_idle(1'b0, 15000, t_done);
        chk("hello_frames", 32'(starts_a.size()), 6);
        for (int i = 1; i < starts_a.size(); i++) chk("hello_gap", 32'(starts_a[i] - starts_a[i-1]), 2340);
        chk("hello_busy", 32'(t_done - starts_a[0]), 14040);
        chk("hello_drained", 32'(exp_a.size()), 0);
        // 4: overfill while a frame is on the wire
        starts_a.delete();
        push_a(8'h55);
        repeat (5) @(posedge clk);
        #1;
        for (int i = 0; i < 17; i++) begin
            in_valid_a = 1'b1;
            in_byte_a  = 8'(i);
            if (i < 16) exp_a.push_back(8'(i));
            @(posedge clk); #1;
            if (i == 15) begin
                chk("full_ready", 32'(in_ready_a), 0);
                chk("full_count", 32'(fifo_count_a), 16);
            end
        end
        in_valid_a = 1'b0;
        chk("full_drop_count", 32'(fifo_count_a), 16);
        wait_idle(1'b0, 41000, t_done);
        chk("fill_frames", 32'(starts_a.size()), 17);
        chk("fill_drained", 32'(exp_a.size()), 0);
        // 5: reset mid-frame with bytes queued
        starts_a.delete();
        push_a(8'hA5);
        push_a(8'h11);
        push_a(8'h22);
        push_a(8'h33);
        repeat (996) @(posedge clk);
        #1;
        chk("abort_queued", 32'(fifo_count_a), 3);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        exp_a.delete();
        chk("abort_tx", 32'(tx_a), 1);
        chk("abort_count", 32'(fifo_count_a), 0);
        chk("abort_busy", 32'(busy_a), 0);
        chk("abort_ready", 32'(in_ready_a), 1);
        errs = 0;
        repeat (3000) begin
            @(posedge clk); #1;
            if (tx_a !== 1'b1 || busy_a !== 1'b0) errs++;
        end
        chk("abort_quiet", 32'(errs), 0);
        chk("abort_no_frames", 32'(starts_a.size()), 0);
        // 6: two stop bits
        push_b(8'hFF);
        push_b(8'h00);
        wait_idle(1'b1, 6000, t_done);
        chk("stop2_frames", 32'(starts_b.size()), 2);
        if (starts_b.size() == 2) chk("stop2_gap", 32'(starts_b[1] - starts_b[0]), 2574);
        chk("stop2_drained", 32'(exp_b.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
